// File: rtl/packet_defs.sv
// Shared L2 header types consumed downstream of the Ethernet header parser.
package packet_defs;

  typedef enum logic [1:0] {
    IPV4 = 2'd0,
    ARP  = 2'd1,
    IPV6 = 2'd2
  } ethertype_e;

  typedef struct packed {
    logic [47:0] dest;
    logic [47:0] source;
    ethertype_e  ethertype;
  } packet_header_t;

endpackage

// File: rtl/eth_header_parser.sv
// Captures the 14-byte L2 header from a framed byte stream, emits one packet_header_t, drains payload.
// Optional ETH_HDR_FILTER_EN: drop frames not addressed to MY_MAC or broadcast (pulses drop_mac).
module eth_header_parser
  import packet_defs::*;
#(
  parameter logic [47:0] MY_MAC = 48'h02_00_00_00_00_01
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     in_data,
  input  logic           in_valid,
  input  logic           in_sof,
  input  logic           in_eof,
  output logic           in_ready,
  output packet_header_t hdr,
  output logic           hdr_valid,
  input  logic           hdr_ready,
  output logic           err_runt,
  output logic           err_type,
  output logic           err_sof
`ifdef ETH_HDR_FILTER_EN
  ,
  output logic           drop_mac
`endif
);

  typedef enum logic [1:0] {IDLE, HDR, HOLD, SKIP} state_e;

  state_e         state_q;
  logic [3:0]     cnt_q;
  logic [95:0]    addr_q;
  logic [7:0]     type_hi_q;
  logic           eof_seen_q;
  packet_header_t hdr_q;
  logic           hdr_valid_q;
  logic           err_runt_q;
  logic           err_type_q;
  logic           err_sof_q;

  logic           xfer;
  logic [15:0]    etype_d;
  logic           type_ok_d;
  ethertype_e     et_d;
  logic           mac_ok_d;

  assign in_ready  = (state_q != HOLD);
  assign xfer      = in_valid && in_ready;
  assign hdr       = hdr_q;
  assign hdr_valid = hdr_valid_q;
  assign err_runt  = err_runt_q;
  assign err_type  = err_type_q;
  assign err_sof   = err_sof_q;
  assign etype_d   = {type_hi_q, in_data};

  always_comb begin
    type_ok_d = 1'b1;
    et_d      = IPV4;
    case (etype_d)
      16'h0800: et_d = IPV4;
      16'h0806: et_d = ARP;
      16'h86DD: et_d = IPV6;
      default:  type_ok_d = 1'b0;
    endcase
  end

`ifdef ETH_HDR_FILTER_EN
  logic drop_mac_q;
  assign drop_mac = drop_mac_q;
  // addr_q[95:48] holds the complete destination once byte 12 has arrived
  assign mac_ok_d = (addr_q[95:48] == MY_MAC) || (addr_q[95:48] == 48'hFFFF_FFFF_FFFF);
`else
  logic unused_mac;
  assign unused_mac = ^MY_MAC;
  assign mac_ok_d   = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      type_hi_q   <= 8'h00;
      eof_seen_q  <= 1'b0;
      hdr_q       <= '0;
      hdr_valid_q <= 1'b0;
      err_runt_q  <= 1'b0;
      err_type_q  <= 1'b0;
      err_sof_q   <= 1'b0;
`ifdef ETH_HDR_FILTER_EN
      drop_mac_q  <= 1'b0;
`endif
    end else begin
      err_runt_q <= 1'b0;
      err_type_q <= 1'b0;
      err_sof_q  <= 1'b0;
`ifdef ETH_HDR_FILTER_EN
      drop_mac_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (xfer && in_sof) begin
            if (in_eof) begin
              err_runt_q <= 1'b1;
            end else begin
              addr_q  <= {addr_q[87:0], in_data};
              cnt_q   <= 4'd1;
              state_q <= HDR;
            end
          end
        end
        HDR: begin
          if (xfer) begin
            if (in_sof) begin
              err_sof_q <= 1'b1;
              addr_q    <= {addr_q[87:0], in_data};
              cnt_q     <= 4'd1;
            end else if (cnt_q == 4'd13) begin
              cnt_q <= 4'd0;
              if (!mac_ok_d) begin
`ifdef ETH_HDR_FILTER_EN
                drop_mac_q <= 1'b1;
`endif
                state_q <= in_eof ? IDLE : SKIP;
              end else if (!type_ok_d) begin
                err_type_q <= 1'b1;
                state_q    <= in_eof ? IDLE : SKIP;
              end else begin
                hdr_q.dest      <= addr_q[95:48];
                hdr_q.source    <= addr_q[47:0];
                hdr_q.ethertype <= et_d;
                hdr_valid_q     <= 1'b1;
                eof_seen_q      <= in_eof;
                state_q         <= HOLD;
              end
            end else if (in_eof) begin
              err_runt_q <= 1'b1;
              cnt_q      <= 4'd0;
              state_q    <= IDLE;
            end else begin
              if (cnt_q == 4'd12) type_hi_q <= in_data;
              else                addr_q    <= {addr_q[87:0], in_data};
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        HOLD: begin
          if (hdr_ready) begin
            hdr_valid_q <= 1'b0;
            state_q     <= eof_seen_q ? IDLE : SKIP;
          end
        end
        SKIP: begin
          if (xfer) begin
            if (in_sof) begin
              err_sof_q <= 1'b1;
              addr_q    <= {addr_q[87:0], in_data};
              cnt_q     <= 4'd1;
              state_q   <= HDR;
            end else if (in_eof) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
